// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bus between the multi-cycle controller and the datapath.
// master = controller (multicycle_ctrl_fsm), slave = datapath side.
interface multicycle_ctrl_fsm_if;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_en;
   logic [1:0] pc_source;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic       ctrl_aluSrcA;
   logic [1:0] ctrl_aluSrcB;
   logic [1:0] ctrl_aluOp;
   logic       illegal_op;

   modport master (
      input  opcode, zero, mem_ready,
      output pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, ctrl_aluSrcA, ctrl_aluSrcB,
             ctrl_aluOp, illegal_op
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, ctrl_aluSrcA, ctrl_aluSrcB,
             ctrl_aluOp, illegal_op
   );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle MIPS core, with retired-instruction counter.
// Define CTRL_JUMP_EN to build the JUMP state (opcode 000010); otherwise j is illegal.
module multicycle_ctrl_fsm #(
   parameter int unsigned CNT_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   multicycle_ctrl_fsm_if.master bus,
   output logic [3:0]            state,
   output logic [CNT_W-1:0]      instr_retired
);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      FETCH     = 4'd1,
      DECODE    = 4'd2,
      MEM_ADDR  = 4'd3,
      MEM_READ  = 4'd4,
      MEM_WB    = 4'd5,
      MEM_WRITE = 4'd6,
      R_EXEC    = 4'd7,
      R_WB      = 4'd8,
      BRANCH    = 4'd9,
`ifdef CTRL_JUMP_EN
      JUMP      = 4'd10,
`endif
      ADDI_EXEC = 4'd11,
      ADDI_WB   = 4'd12
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
`ifdef CTRL_JUMP_EN
   localparam logic [5:0] OP_J    = 6'b000010;
`endif

   state_t cur_state, nxt_state;
   logic   is_store;
   logic   pc_write, pc_write_cond, retire;

   // lw/sw choice is latched at DECODE so MEM_ADDR does not depend on a stable IR.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state     <= IDLE;
         is_store      <= 1'b0;
         instr_retired <= '0;
      end else begin
         cur_state <= nxt_state;
         if (cur_state == DECODE)
            is_store <= (bus.opcode == OP_SW);
         if (retire)
            instr_retired <= instr_retired + CNT_W'(1);
      end
   end

   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         IDLE:      nxt_state = FETCH;
         FETCH:     if (bus.mem_ready) nxt_state = DECODE;
         DECODE: begin
            case (bus.opcode)
               OP_R:         nxt_state = R_EXEC;
               OP_LW, OP_SW: nxt_state = MEM_ADDR;
               OP_BEQ:       nxt_state = BRANCH;
               OP_ADDI:      nxt_state = ADDI_EXEC;
`ifdef CTRL_JUMP_EN
               OP_J:         nxt_state = JUMP;
`endif
               default:      nxt_state = FETCH;
            endcase
         end
         MEM_ADDR:  nxt_state = is_store ? MEM_WRITE : MEM_READ;
         MEM_READ:  if (bus.mem_ready) nxt_state = MEM_WB;
         MEM_WRITE: if (bus.mem_ready) nxt_state = FETCH;
         R_EXEC:    nxt_state = R_WB;
         ADDI_EXEC: nxt_state = ADDI_WB;
`ifdef CTRL_JUMP_EN
         JUMP,
`endif
         MEM_WB, R_WB, ADDI_WB, BRANCH: nxt_state = FETCH;
         default:   nxt_state = IDLE;
      endcase
   end

   always_comb begin
      pc_write         = 1'b0;
      pc_write_cond    = 1'b0;
      retire           = 1'b0;
      bus.pc_source    = '0;
      bus.i_or_d       = 1'b0;
      bus.mem_read     = 1'b0;
      bus.mem_write    = 1'b0;
      bus.ir_write     = 1'b0;
      bus.reg_dst      = 1'b0;
      bus.mem_to_reg   = 1'b0;
      bus.reg_write    = 1'b0;
      bus.ctrl_aluSrcA = 1'b0;
      bus.ctrl_aluSrcB = '0;
      bus.ctrl_aluOp   = '0;
      bus.illegal_op   = 1'b0;
      case (cur_state)
         FETCH: begin
            bus.mem_read     = 1'b1;
            bus.ctrl_aluSrcB = 2'b01;
            bus.ir_write     = bus.mem_ready;
            pc_write         = bus.mem_ready;
         end
         DECODE: begin
            bus.ctrl_aluSrcB = 2'b11;
            case (bus.opcode)
`ifdef CTRL_JUMP_EN
               OP_J,
`endif
               OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI: bus.illegal_op = 1'b0;
               default:                             bus.illegal_op = 1'b1;
            endcase
         end
         MEM_ADDR, ADDI_EXEC: begin
            bus.ctrl_aluSrcA = 1'b1;
            bus.ctrl_aluSrcB = 2'b10;
         end
         MEM_READ: begin
            bus.mem_read = 1'b1;
            bus.i_or_d   = 1'b1;
         end
         MEM_WB: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = 1'b1;
            retire         = 1'b1;
         end
         MEM_WRITE: begin
            bus.mem_write = 1'b1;
            bus.i_or_d    = 1'b1;
            retire        = bus.mem_ready;
         end
         R_EXEC: begin
            bus.ctrl_aluSrcA = 1'b1;
            bus.ctrl_aluOp   = 2'b10;
         end
         R_WB: begin
            bus.reg_write = 1'b1;
            bus.reg_dst   = 1'b1;
            retire        = 1'b1;
         end
         ADDI_WB: begin
            bus.reg_write = 1'b1;
            retire        = 1'b1;
         end
         BRANCH: begin
            bus.ctrl_aluSrcA = 1'b1;
            bus.ctrl_aluOp   = 2'b01;
            bus.pc_source    = 2'b01;
            pc_write_cond    = 1'b1;
            retire           = 1'b1;
         end
`ifdef CTRL_JUMP_EN
         JUMP: begin
            bus.pc_source = 2'b10;
            pc_write      = 1'b1;
            retire        = 1'b1;
         end
`endif
         default: ;
      endcase
      bus.pc_en = pc_write | (pc_write_cond & bus.zero);
   end

   assign state = cur_state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: per-cycle expected state/controls/count queue.
// A second instance with CNT_W=2 runs in lockstep to exercise counter wrap.
module tb_multicycle_ctrl_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  opcode;
   logic        zero;
   logic        mem_ready;
   logic [3:0]  state1, state2;
   logic [31:0] cnt1;
   logic [1:0]  cnt2;
   logic [31:0] exp_cnt;
   int          n_tests = 0;
   int          n_fail  = 0;

   typedef struct packed {
      logic        mr;
      logic [3:0]  st;
      logic [15:0] ctrl;
      logic [31:0] cnt;
   } exp_t;
   exp_t q[$];

   multicycle_ctrl_fsm_if bus1();
   multicycle_ctrl_fsm_if bus2();
   assign bus1.opcode = opcode;
   assign bus2.opcode = opcode;
   assign bus1.zero = zero;
   assign bus2.zero = zero;
   assign bus1.mem_ready = mem_ready;
   assign bus2.mem_ready = mem_ready;

   multicycle_ctrl_fsm #(.CNT_W(32)) u_dut (
      .clk(clk), .reset(reset), .bus(bus1), .state(state1), .instr_retired(cnt1));
   multicycle_ctrl_fsm #(.CNT_W(2)) u_dut2 (
      .clk(clk), .reset(reset), .bus(bus2), .state(state2), .instr_retired(cnt2));

   always #5 clk = ~clk;

   // {pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
   //  reg_write, aluSrcA, aluSrcB, aluOp, illegal_op}
   function automatic logic [15:0] act_ctrl();
      return {bus1.pc_en, bus1.pc_source, bus1.i_or_d, bus1.mem_read, bus1.mem_write,
              bus1.ir_write, bus1.reg_dst, bus1.mem_to_reg, bus1.reg_write,
              bus1.ctrl_aluSrcA, bus1.ctrl_aluSrcB, bus1.ctrl_aluOp, bus1.illegal_op};
   endfunction

   function automatic logic [15:0] exp_ctrl(int st, logic mr, logic z, logic [5:0] op);
      logic pw = 0, pwc = 0, iod = 0, mrd = 0, mwr = 0, irw = 0, rd = 0, m2r = 0;
      logic rw = 0, sa = 0, ill = 0;
      logic [1:0] ps = 0, sb = 0, ao = 0;
      case (st)
         1: begin mrd = 1; sb = 2'b01; pw = mr; irw = mr; end
         2: begin
            sb = 2'b11;
            ill = !(op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
                    op == 6'b000100 || op == 6'b001000
`ifdef CTRL_JUMP_EN
                    || op == 6'b000010
`endif
                   );
         end
         3, 11: begin sa = 1; sb = 2'b10; end
         4: begin mrd = 1; iod = 1; end
         5: begin rw = 1; m2r = 1; end
         6: begin mwr = 1; iod = 1; end
         7: begin sa = 1; ao = 2'b10; end
         8: begin rw = 1; rd = 1; end
         9: begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
         10: begin pw = 1; ps = 2'b10; end
         12: rw = 1;
         default: ;
      endcase
      return {pw | (pwc & z), ps, iod, mrd, mwr, irw, rd, m2r, rw, sa, sb, ao, ill};
   endfunction

   task automatic push(input logic mr, input int st);
      exp_t e;
      e.mr   = mr;
      e.st   = 4'(st);
      e.ctrl = exp_ctrl(st, mr, zero, opcode);
      e.cnt  = exp_cnt;
      q.push_back(e);
      if (st == 5 || st == 8 || st == 12 || st == 9 || st == 10 || (st == 6 && mr))
         exp_cnt = exp_cnt + 1;
   endtask

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic drain(input string name);
      exp_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         mem_ready = e.mr;
         @(negedge clk);
         n_tests++;
         if (state1 !== e.st) begin
            n_fail++;
            $display("FAIL %s state: got %0d exp %0d", name, state1, e.st);
         end
         n_tests++;
         if (act_ctrl() !== e.ctrl) begin
            n_fail++;
            $display("FAIL %s ctrl (st %0d): got %h exp %h", name, e.st, act_ctrl(), e.ctrl);
         end
         n_tests++;
         if (cnt1 !== e.cnt) begin
            n_fail++;
            $display("FAIL %s count: got %0d exp %0d", name, cnt1, e.cnt);
         end
         n_tests++;
         if (cnt2 !== e.cnt[1:0]) begin
            n_fail++;
            $display("FAIL %s count_w2: got %0d exp %0d", name, cnt2, e.cnt[1:0]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_instr(input string name, input logic [5:0] op, input logic z,
                            input int fstall, input int mstall);
      opcode = op;
      zero   = z;
      for (int i = 0; i < fstall; i++) push(1'b0, 1);
      push(1'b1, 1);
      push(rnd(), 2);
      case (op)
         6'b100011: begin
            push(rnd(), 3);
            for (int i = 0; i < mstall; i++) push(1'b0, 4);
            push(1'b1, 4);
            push(rnd(), 5);
         end
         6'b101011: begin
            push(rnd(), 3);
            for (int i = 0; i < mstall; i++) push(1'b0, 6);
            push(1'b1, 6);
         end
         6'b000000: begin push(rnd(), 7); push(rnd(), 8); end
         6'b001000: begin push(rnd(), 11); push(rnd(), 12); end
         6'b000100: push(rnd(), 9);
`ifdef CTRL_JUMP_EN
         6'b000010: push(rnd(), 10);
`endif
         default: ;
      endcase
      drain(name);
   endtask

   task automatic check_zeroed(input string name);
      n_tests++;
      if (state1 !== 4'd0 || act_ctrl() !== 16'h0) begin
         n_fail++;
         $display("FAIL %s: state %0d ctrl %h, exp 0 0", name, state1, act_ctrl());
      end
      n_tests++;
      if (cnt1 !== 32'd0 || cnt2 !== 2'd0) begin
         n_fail++;
         $display("FAIL %s count: got %0d/%0d exp 0", name, cnt1, cnt2);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b1;
      exp_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      check_zeroed("reset");
      reset = 1'b0;
      push(rnd(), 0);
      drain("idle");
   endtask

   task automatic test_lw();
      run_instr("lw", 6'b100011, 1'b0, 0, 0);
      run_instr("lw_stall", 6'b100011, 1'b1, 0, 2);
   endtask

   task automatic test_fetch_stall();
      run_instr("fetch_stall", 6'b000000, 1'b0, 3, 0);
   endtask

   task automatic test_sw_addi();
      run_instr("sw", 6'b101011, 1'b0, 0, 0);
      run_instr("sw_stall", 6'b101011, 1'b1, 1, 3);
      run_instr("addi", 6'b001000, 1'b1, 0, 0);
   endtask

   task automatic test_branch();
      run_instr("beq_taken", 6'b000100, 1'b1, 0, 0);
      run_instr("beq_not", 6'b000100, 1'b0, 0, 0);
   endtask

   task automatic test_illegal();
      run_instr("illegal", 6'b111111, 1'b1, 0, 0);
      run_instr("jump", 6'b000010, 1'b1, 0, 0);
      run_instr("after_illegal", 6'b000000, 1'b0, 0, 0);
   endtask

   task automatic test_back_to_back();
      logic [5:0] ops [7];
      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010, 6'b010101};
      for (int i = 0; i < 20; i++)
         run_instr("b2b", ops[$urandom_range(0, 6)], rnd(), $urandom_range(0, 2),
                   $urandom_range(0, 2));
   endtask

   task automatic test_reset_mid_write();
      opcode = 6'b101011; zero = 1'b0;
      push(1'b1, 1);
      push(rnd(), 2);
      push(rnd(), 3);
      push(1'b0, 6);
      drain("sw_pre_reset");
      reset = 1'b1;
      #1;
      check_zeroed("reset_mid_write");
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_cnt = 0;
      push(rnd(), 0);
      drain("idle_after_reset");
      run_instr("r_after_reset", 6'b000000, 1'b0, 0, 0);
   endtask

   task automatic test_wrap();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_cnt = 0;
      push(rnd(), 0);
      drain("wrap_idle");
      for (int i = 0; i < 5; i++) begin
         run_instr("wrap_r", 6'b000000, 1'b0, 0, 0);
      end
      @(negedge clk);
      n_tests++;
      if (cnt2 !== 2'd1 || cnt1 !== 32'd5) begin
         n_fail++;
         $display("FAIL wrap_final: got %0d/%0d exp 1/5", cnt2, cnt1);
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_fetch_stall();
      test_sw_addi();
      test_branch();
      test_illegal();
      test_back_to_back();
      test_reset_mid_write();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
